// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared types and helpers for the branch predictor.
// Holds counter encodings, PC index/tag slicing and the BTB entry layout.
package branch_predictor_pkg;

    localparam int unsigned BP_IDX_W    = 6;
    localparam int unsigned BP_TAG_W    = 8;
    localparam logic [1:0]  BP_CTR_INIT = 2'b10;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    // Tag field is sized for the widest possible tag so the entry type does
    // not depend on the top-level parameters; unused high bits stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        logic [1:0]  ctr;
    } bp_entry_t;

    localparam bp_entry_t BP_ENTRY_RST = '{
        valid:  1'b0,
        tag:    30'd0,
        target: 30'd0,
        ctr:    WNT
    };

    function automatic logic [29:0] bp_idx(
        input logic [31:0] pc,
        input int unsigned idx_w
    );
        return pc[31:2] & ((30'd1 << idx_w) - 30'd1);
    endfunction

    function automatic logic [29:0] bp_tag(
        input logic [31:0] pc,
        input int unsigned idx_w,
        input int unsigned tag_w
    );
        return (pc[31:2] >> idx_w) & ((30'd1 << tag_w) - 30'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: lookup (fetch) and update (decode) signal bundle.
// master = fetch/decode side, slave = predictor; lk_* lookup, upd_* training, flush.
interface branch_predictor_if;
    logic [31:0] lk_pc;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jbr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush;

    modport master (
        output lk_pc, upd_valid, upd_pc, upd_is_jbr, upd_taken,
        output upd_target, upd_pred_taken, upd_pred_target, flush,
        input  lk_hit, lk_taken, lk_target
    );

    modport slave (
        input  lk_pc, upd_valid, upd_pc, upd_is_jbr, upd_taken,
        input  upd_target, upd_pred_taken, upd_pred_target, flush,
        output lk_hit, lk_taken, lk_target
    );
endinterface

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: 2-bit saturating counter next-state (no wrap at 0 or 3).
// Ports: ctr_i current value, taken_i direction, ctr_o next value.
module bp_sat_ctr
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, 0-cycle lookup.
// Ports: clk, reset (async high), bp (slave: lookup/update/flush bundle);
// with BP_STATS_EN defined also stat_jbr and stat_mispred (32-bit counters).
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_W    = BP_IDX_W,
    parameter int unsigned TAG_W    = BP_TAG_W,
    parameter logic [1:0]  CTR_INIT = BP_CTR_INIT
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0]        stat_jbr,
    output logic [31:0]        stat_mispred
`endif
);
    localparam int DEPTH = 1 << IDX_W;

    bp_entry_t        tbl_q [DEPTH];
    bp_entry_t        tbl_d [DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [29:0]      lk_tag;
    bp_entry_t        lk_ent;
    logic             lk_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [29:0]      upd_tag;
    bp_entry_t        upd_ent;
    logic             upd_hit;
    logic [1:0]       upd_ctr_nxt;

    // Lookup reads registered state only; same-cycle updates are not bypassed.
    assign lk_idx = IDX_W'(bp_idx(bp.lk_pc, IDX_W));
    assign lk_tag = bp_tag(bp.lk_pc, IDX_W, TAG_W);
    assign lk_ent = tbl_q[lk_idx];
    assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

    assign bp.lk_hit    = lk_hit;
    assign bp.lk_taken  = lk_hit & lk_ent.ctr[1];
    assign bp.lk_target = lk_hit ? {lk_ent.target, 2'b00} : 32'd0;

    assign upd_idx = IDX_W'(bp_idx(bp.upd_pc, IDX_W));
    assign upd_tag = bp_tag(bp.upd_pc, IDX_W, TAG_W);
    assign upd_ent = tbl_q[upd_idx];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

    bp_sat_ctr u_sat_ctr (
        .ctr_i   (upd_ent.ctr),
        .taken_i (bp.upd_taken),
        .ctr_o   (upd_ctr_nxt)
    );

    always_comb begin
        tbl_d = tbl_q;
        if (bp.flush) begin
            // Flush drops only valid bits; counters and targets are kept.
            for (int i = 0; i < DEPTH; i++) begin
                tbl_d[i].valid = 1'b0;
            end
        end else if (bp.upd_valid) begin
            if (bp.upd_is_jbr) begin
                if (upd_hit) begin
                    tbl_d[upd_idx].ctr = upd_ctr_nxt;
                    if (bp.upd_taken) begin
                        tbl_d[upd_idx].target = bp.upd_target[31:2];
                    end
                end else if (bp.upd_taken) begin
                    tbl_d[upd_idx] = '{
                        valid:  1'b1,
                        tag:    upd_tag,
                        target: bp.upd_target[31:2],
                        ctr:    CTR_INIT
                    };
                end
            end else if (upd_hit) begin
                // A non-branch matched: stale alias, retire the entry.
                tbl_d[upd_idx].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= BP_ENTRY_RST;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^bp.upd_target[1:0];

`ifdef BP_STATS_EN
    logic [31:0] stat_jbr_q;
    logic [31:0] stat_jbr_d;
    logic [31:0] stat_mis_q;
    logic [31:0] stat_mis_d;
    logic        upd_jbr;
    logic        upd_mis;

    assign upd_jbr = bp.upd_valid & bp.upd_is_jbr;
    assign upd_mis = upd_jbr &
        ((bp.upd_pred_taken != bp.upd_taken) |
         (bp.upd_taken & bp.upd_pred_taken &
          (bp.upd_pred_target != bp.upd_target)));

    assign stat_jbr_d = stat_jbr_q + {31'd0, upd_jbr};
    assign stat_mis_d = stat_mis_q + {31'd0, upd_mis};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_jbr_q <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            stat_jbr_q <= stat_jbr_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_jbr     = stat_jbr_q;
    assign stat_mispred = stat_mis_q;
`else
    logic unused_pred;
    assign unused_pred = ^{bp.upd_pred_taken, bp.upd_pred_target};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table + scoreboard bench for branch_predictor.
// Define BP_STATS_EN to also exercise the statistics counters.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_predictor_if bp_if ();

`ifdef BP_STATS_EN
    logic [31:0] stat_jbr;
    logic [31:0] stat_mispred;
`endif

    branch_predictor dut (
        .clk          (clk),
        .reset        (reset),
        .bp           (bp_if.slave)
`ifdef BP_STATS_EN
        ,
        .stat_jbr     (stat_jbr),
        .stat_mispred (stat_mispred)
`endif
    );

    typedef struct {
        logic [31:0] lk;
        logic        uv;
        logic [31:0] upc;
        logic        jbr;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        fl;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
    } vec_t;

    typedef struct {
        logic        h;
        logic        t;
        logic [31:0] g;
        string       nm;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_jbr = 32'd0;
    logic [31:0] m_mis = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h need %h", nm, act, req);
        end
    endtask

    // lookup-only row (no update)
    task automatic add_lk(input logic [31:0] lk, input logic eh,
                          input logic et, input logic [31:0] etgt);
        vecs.push_back('{lk, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0,
                         1'b0, 32'd0, 1'b0, eh, et, etgt});
    endtask

    // lookup plus update row
    task automatic add_up(input logic [31:0] lk, input logic [31:0] upc,
                          input logic jbr, input logic tk,
                          input logic [31:0] tgt, input logic fl,
                          input logic eh, input logic et,
                          input logic [31:0] etgt);
        vecs.push_back('{lk, 1'b1, upc, jbr, tk, tgt,
                         1'b0, 32'd0, fl, eh, et, etgt});
    endtask

    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #2;
        bp_if.lk_pc           = v.lk;
        bp_if.upd_valid       = v.uv;
        bp_if.upd_pc          = v.upc;
        bp_if.upd_is_jbr      = v.jbr;
        bp_if.upd_taken       = v.tk;
        bp_if.upd_target      = v.tgt;
        bp_if.upd_pred_taken  = v.ptk;
        bp_if.upd_pred_target = v.ptgt;
        bp_if.flush           = v.fl;
        if (v.uv && v.jbr) begin
            m_jbr++;
            if ((v.ptk != v.tk) || (v.tk && v.ptk && (v.ptgt != v.tgt)))
                m_mis++;
        end
        e = '{v.eh, v.et, v.etgt, nm};
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        chk({got.nm, "_hit"}, {31'd0, bp_if.lk_hit}, {31'd0, got.h});
        chk({got.nm, "_taken"}, {31'd0, bp_if.lk_taken}, {31'd0, got.t});
        chk({got.nm, "_target"}, bp_if.lk_target, got.g);
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        bp_if.upd_valid = 1'b0;
        bp_if.flush     = 1'b0;
        #2;
    endtask

    initial begin
        bp_if.lk_pc           = 32'h40;
        bp_if.upd_valid       = 1'b0;
        bp_if.upd_pc          = 32'd0;
        bp_if.upd_is_jbr      = 1'b0;
        bp_if.upd_taken       = 1'b0;
        bp_if.upd_target      = 32'd0;
        bp_if.upd_pred_taken  = 1'b0;
        bp_if.upd_pred_target = 32'd0;
        bp_if.flush           = 1'b0;
        reset = 1'b1;

        #12;
        chk("rst_hit", {31'd0, bp_if.lk_hit}, 32'd0);
        chk("rst_taken", {31'd0, bp_if.lk_taken}, 32'd0);
        chk("rst_target", bp_if.lk_target, 32'd0);
`ifdef BP_STATS_EN
        chk("rst_stat_jbr", stat_jbr, 32'd0);
        chk("rst_stat_mis", stat_mispred, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        add_lk(32'h40, 0, 0, 32'h0);
        add_up(32'h40, 32'h40, 1, 1, 32'h100, 0, 0, 0, 32'h0);
        add_lk(32'h40, 1, 1, 32'h100);
        add_lk(32'h140, 0, 0, 32'h0);
        add_up(32'h40, 32'h40, 1, 1, 32'h100, 0, 1, 1, 32'h100);
        add_up(32'h40, 32'h40, 1, 1, 32'h100, 0, 1, 1, 32'h100);
        add_up(32'h40, 32'h40, 1, 1, 32'h100, 0, 1, 1, 32'h100);
        add_up(32'h40, 32'h40, 1, 0, 32'h0, 0, 1, 1, 32'h100);
        add_up(32'h40, 32'h40, 1, 0, 32'h0, 0, 1, 1, 32'h100);
        add_lk(32'h40, 1, 0, 32'h100);
        add_up(32'h40, 32'h40, 1, 0, 32'h0, 0, 1, 0, 32'h100);
        add_up(32'h40, 32'h40, 1, 0, 32'h0, 0, 1, 0, 32'h100);
        add_up(32'h40, 32'h40, 1, 1, 32'h100, 0, 1, 0, 32'h100);
        add_lk(32'h40, 1, 0, 32'h100);
        add_up(32'h40, 32'h40, 1, 1, 32'h204, 0, 1, 0, 32'h100);
        add_lk(32'h40, 1, 1, 32'h204);
        add_up(32'h40, 32'h40, 1, 0, 32'h998, 0, 1, 1, 32'h204);
        add_lk(32'h40, 1, 0, 32'h204);
        add_up(32'h80, 32'h80, 1, 1, 32'h300, 0, 0, 0, 32'h0);
        add_lk(32'h80, 1, 1, 32'h300);
        add_up(32'hC0, 32'hC0, 1, 0, 32'h400, 0, 0, 0, 32'h0);
        add_lk(32'hC0, 0, 0, 32'h0);
        add_up(32'h40, 32'h140, 0, 0, 32'h0, 0, 1, 0, 32'h204);
        add_lk(32'h40, 1, 0, 32'h204);
        add_up(32'h40, 32'h140, 1, 1, 32'h500, 0, 1, 0, 32'h204);
        add_lk(32'h140, 1, 1, 32'h500);
        add_lk(32'h40, 0, 0, 32'h0);
        add_up(32'h80, 32'h200, 1, 1, 32'h600, 1, 1, 1, 32'h300);
        add_lk(32'h80, 0, 0, 32'h0);
        add_lk(32'h200, 0, 0, 32'h0);
        add_lk(32'h140, 0, 0, 32'h0);
        add_up(32'h40, 32'h40, 1, 1, 32'h100, 0, 0, 0, 32'h0);
        add_up(32'h40, 32'h40, 0, 0, 32'h0, 0, 1, 1, 32'h100);
        add_lk(32'h40, 0, 0, 32'h0);
        add_up(32'h40, 32'h42, 1, 1, 32'h107, 0, 0, 0, 32'h0);
        add_lk(32'h41, 1, 1, 32'h104);
        vecs.push_back('{32'h43, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0,
                         1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h104});
        add_lk(32'h40, 1, 1, 32'h104);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end
        idle();

`ifdef BP_STATS_EN
        chk("vec_stat_jbr", stat_jbr, m_jbr);
        chk("vec_stat_mis", stat_mispred, m_mis);
        begin
            logic [31:0] b_jbr;
            logic [31:0] b_mis;
            vec_t        v;
            b_jbr = m_jbr;
            b_mis = m_mis;
            for (int i = 0; i < 10; i++) begin
                v = '{32'h2000, 1'b1, 32'h1000 + 32'(i * 4), 1'b1,
                      1'b0, 32'h3000, 1'b0, 32'h3000, 1'b0,
                      1'b0, 1'b0, 32'h0};
                v.tk  = (i % 2) == 0;
                v.ptk = v.tk;
                if (i == 0 || i == 2) v.ptk = 1'b0;
                if (i == 1) v.ptk = 1'b1;
                if (i == 3) begin
                    v.tk   = 1'b1;
                    v.ptk  = 1'b1;
                    v.ptgt = 32'h3004;
                end
                apply(v, $sformatf("s%0d", i));
            end
            idle();
            chk("stat_jbr_10", stat_jbr, b_jbr + 32'd10);
            chk("stat_mis_4", stat_mispred, b_mis + 32'd4);
            v = '{32'h2000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
            apply(v, "sflush");
            idle();
            chk("flush_stat_jbr", stat_jbr, b_jbr + 32'd10);
            chk("flush_stat_mis", stat_mispred, b_mis + 32'd4);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
